// File: rtl/line_engine.sv
// Bresenham line rasteriser: all octants, both endpoints emitted,
// pixels leave on a valid/ready stream tagged with a per-line colour.
module line_engine #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] color,
  output logic          busy,
  output logic          done,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic [CW-1:0] px_color
);

  localparam int MW = (XW > YW) ? XW : YW;
  localparam int EW = MW + 2;

  typedef enum logic [2:0] {
    IDLE, SETUP, PREP, DRAW, DONE
  } state_t;

  state_t state, state_n;

  logic [MW-1:0] ax0, ay0, ax1, ay1;
  logic [MW-1:0] maj0, min0, maj1, min1;
  logic [MW-1:0] dmaj, dmin, cur_maj, cur_min;
  logic          steep, step_up;
  logic signed [EW-1:0] err;

  logic signed [MW:0] ddx, ddy, adx, ady;
  logic          s_steep;
  logic [MW-1:0] a_maj0, a_min0, a_maj1, a_min1;
  logic [MW-1:0] s_maj0, s_min0, s_maj1, s_min1;

  always_comb begin
    ddx = $signed({1'b0, ax1}) - $signed({1'b0, ax0});
    ddy = $signed({1'b0, ay1}) - $signed({1'b0, ay0});
    adx = ddx[MW] ? -ddx : ddx;
    ady = ddy[MW] ? -ddy : ddy;
    s_steep = ady > adx;
    a_maj0 = s_steep ? ay0 : ax0;
    a_min0 = s_steep ? ax0 : ay0;
    a_maj1 = s_steep ? ay1 : ax1;
    a_min1 = s_steep ? ax1 : ay1;
    s_maj0 = a_maj0;
    s_min0 = a_min0;
    s_maj1 = a_maj1;
    s_min1 = a_min1;
    if (a_maj0 > a_maj1) begin
      s_maj0 = a_maj1;
      s_min0 = a_min1;
      s_maj1 = a_maj0;
      s_min1 = a_min0;
    end
  end

  logic [MW-1:0] dmaj_c;
  logic          hs, last;
  logic signed [EW-1:0] t, nx_err;
  logic [MW-1:0] nx_maj, nx_min, ld_maj, ld_min;

  always_comb begin
    dmaj_c = maj1 - maj0;
    hs     = px_valid & px_ready;
    last   = cur_maj == maj1;
    t      = err + $signed({2'b00, dmin});
    nx_maj = cur_maj + MW'(1);
    nx_min = cur_min;
    nx_err = t;
    if (!t[EW-1]) begin
      nx_min = step_up ? cur_min + MW'(1) : cur_min - MW'(1);
      nx_err = t - $signed({2'b00, dmaj});
    end
    ld_maj = (state == PREP) ? maj0 : nx_maj;
    ld_min = (state == PREP) ? min0 : nx_min;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    busy     = state != IDLE;
    done     = state == DONE;
    px_valid = state == DRAW;
    unique case (state)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   state_n = PREP;
      PREP:    state_n = DRAW;
      DRAW:    if (hs && last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ax0 <= '0; ay0 <= '0; ax1 <= '0; ay1 <= '0;
      maj0 <= '0; min0 <= '0; maj1 <= '0; min1 <= '0;
      dmaj <= '0; dmin <= '0;
      cur_maj <= '0; cur_min <= '0;
      steep <= 1'b0; step_up <= 1'b0;
      err <= '0;
      px_x <= '0; px_y <= '0; px_color <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          ax0 <= MW'(x0);
          ax1 <= MW'(x1);
          ay0 <= MW'(y0);
          ay1 <= MW'(y1);
          px_color <= color;
        end
        SETUP: begin
          steep <= s_steep;
          maj0 <= s_maj0;
          min0 <= s_min0;
          maj1 <= s_maj1;
          min1 <= s_min1;
        end
        PREP: begin
          dmaj    <= dmaj_c;
          dmin    <= (min1 >= min0) ? min1 - min0 : min0 - min1;
          step_up <= min1 > min0;
          err     <= -$signed({2'b00, dmaj_c >> 1});
          cur_maj <= maj0;
          cur_min <= min0;
          px_x    <= XW'(steep ? ld_min : ld_maj);
          px_y    <= YW'(steep ? ld_maj : ld_min);
        end
        DRAW: if (hs && !last) begin
          cur_maj <= nx_maj;
          cur_min <= nx_min;
          err     <= nx_err;
          px_x    <= XW'(steep ? ld_min : ld_maj);
          px_y    <= YW'(steep ? ld_maj : ld_min);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_engine.sv
// Directed bench for line_engine: exact pixel lists, timing,
// backpressure, full-range diagonal and mid-line reset.
module tb_line_engine;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [XW-1:0] x0 = '0, x1 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0;
  logic [CW-1:0] color = '0;
  logic          busy, done, px_valid;
  logic          px_ready = 1'b1;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [CW-1:0] px_color;

  line_engine #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .busy(busy), .done(done), .px_valid(px_valid),
    .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .px_color(px_color)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ex_q[$];
  int ey_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: exact list in ex_q/ey_q; mode 1: full-range diagonal properties
  task automatic run_line(input int ax0, input int ay0,
                          input int ax1, input int ay1,
                          input int col, input int mode,
                          input int stall_idx, input int stall_len,
                          input int lat_chk);
    int idx, k, first_k, rec_k, done_k, stalled, n_exp;
    int prev_x, prev_y, dy;
    idx = 0; k = 0; first_k = -1; rec_k = -1;
    done_k = -1; stalled = 0; prev_x = 0; prev_y = 0;
    n_exp = (mode == 0) ? ex_q.size() : 640;
    @(negedge clk);
    x0 = XW'(ax0); y0 = YW'(ay0);
    x1 = XW'(ax1); y1 = YW'(ay1);
    color = CW'(col); start = 1'b1; px_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (done) begin
        done_k = k;
        break;
      end
      if (px_valid) begin
        if (first_k < 0) first_k = k;
        if (idx == stall_idx && stalled < stall_len) begin
          px_ready = 1'b0;
          stalled++;
          start = 1'b1;
          x0 = 10'd50; y0 = 9'd40; x1 = 10'd60; y1 = 9'd45;
          color = ~CW'(col);
          chk("hold_x", px_x, ex_q[idx]);
          chk("hold_y", px_y, ey_q[idx]);
          chk("hold_color", px_color, col);
        end else begin
          px_ready = 1'b1;
          start = 1'b0;
          if (mode == 0) begin
            if (idx < n_exp) begin
              chk("pix_x", px_x, ex_q[idx]);
              chk("pix_y", px_y, ey_q[idx]);
              chk("pix_color", px_color, col);
            end else begin
              chk("extra_pixel", idx, n_exp);
            end
          end else begin
            if (idx == 0) begin
              chk("diag_first_x", px_x, 0);
              chk("diag_first_y", px_y, 0);
            end else begin
              dy = int'(px_y) - prev_y;
              chk("diag_x_step", px_x, prev_x + 1);
              chk("diag_y_step", int'(dy == 0 || dy == 1), 1);
            end
            chk("diag_color", px_color, col);
            prev_x = int'(px_x);
            prev_y = int'(px_y);
          end
          idx++;
          rec_k = k;
        end
      end
    end
    px_ready = 1'b1;
    start = 1'b0;
    if (done_k < 0) chk("done_timeout", 0, 1);
    chk("pixel_count", idx, n_exp);
    chk("done_after_last", done_k, rec_k + 1);
    if (mode == 1) begin
      chk("diag_last_x", prev_x, 639);
      chk("diag_last_y", prev_y, 479);
    end
    if (lat_chk != 0) chk("first_latency", first_k, 3);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int k, cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", px_valid, 0);
    chk("rst_px_x", px_x, 0);
    chk("rst_px_y", px_y, 0);
    chk("rst_color", px_color, 0);
    reset = 1'b0;

    ex_q = '{0, 1, 2, 3, 4, 5};
    ey_q = '{0, 0, 0, 0, 0, 0};
    run_line(0, 0, 5, 0, 0, 0, -1, 0, 1);

    ex_q = '{2, 2, 3, 3, 3, 4, 4};
    ey_q = '{1, 2, 3, 4, 5, 6, 7};
    run_line(2, 1, 4, 7, 1, 0, -1, 0, 1);

    ex_q = '{0, 1, 2, 3, 4, 5};
    ey_q = '{0, 1, 1, 2, 3, 3};
    run_line(5, 3, 0, 0, 0, 0, -1, 0, 0);

    ex_q = '{7};
    ey_q = '{7};
    run_line(7, 7, 7, 7, 1, 0, -1, 0, 1);

    ex_q = '{0, 1, 2, 3};
    ey_q = '{0, 1, 2, 3};
    run_line(0, 0, 3, 3, 1, 0, 1, 3, 1);

    run_line(639, 479, 0, 0, 1, 1, -1, 0, 1);

    @(negedge clk);
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd99; y1 = 9'd0;
    color = 1'b1; start = 1'b1; px_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; cnt = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (px_valid) begin
        if (cnt == 9) break;
        cnt++;
      end
    end
    chk("pix10_reached", cnt, 9);
    chk("pix10_x", px_x, 9);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", px_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_px_x", px_x, 0);

    ex_q = '{0, 1, 2, 3};
    ey_q = '{2, 1, 0, 0};
    run_line(3, 0, 0, 2, 0, 0, -1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_engine.md
# line_engine

Parametrised Bresenham line rasteriser and successor to the fixed 640x480 line drawer. It accepts one line command at a time through a start/busy handshake, covers all octants, and emits every pixel on the line, both endpoints included. Pixels leave through a valid/ready stream with a per-line colour tag, so the engine can feed a framebuffer writer that stalls. It sits between the drawing command source and the VGA framebuffer write port.

## Interface
- XW, default 10: x coordinate width (default range 0-639).
- YW, default 9: y coordinate width (default range 0-479).
- CW, default 1: colour tag width.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only while idle.
- x0, x1  in  XW  endpoint x coordinates (unsigned).
- y0, y1  in  YW  endpoint y coordinates (unsigned).
- color  in  CW  colour tag, captured with the command.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse after the last pixel handshake.
- px_valid  out  1  pixel output valid.
- px_ready  in  1  downstream accepts the pixel.
- px_x  out  XW  pixel x.
- px_y  out  YW  pixel y.
- px_color  out  CW  captured colour.

## Operation
- MW = max(XW, YW). Internal major and minor coordinates are MW bits wide. No truncation occurs when axes are exchanged.
- Error register is signed, MW+2 bits wide.
- States: IDLE -> SETUP -> PREP -> DRAW -> DONE -> IDLE.
- **IDLE**
  - If start=1: latch x0, x1, y0, y1 and color, then go to SETUP.
  - start is level-sampled. An idle engine with start held high accepts a new command every time it returns to IDLE.
- **SETUP**
  - steep = |y1-y0| > |x1-x0|, computed at MW+1 bits signed.
  - If steep, swap x and y of both endpoints.
  - If the major coordinate of endpoint 0 exceeds that of endpoint 1, swap the endpoints.
  - Store steep.
- **PREP**
  - dmaj = maj1 - maj0.
  - dmin = |min1 - min0|.
  - step = +1 if min1 > min0, else -1.
  - err = -(dmaj >> 1).
  - cur_maj = maj0, cur_min = min0.
  - Go to DRAW.
- **DRAW**
  - px_valid = 1.
  - px_x/px_y = (cur_min, cur_maj) if steep, else (cur_maj, cur_min), each truncated to its port width.
  - On a handshake (px_valid & px_ready):
    - If cur_maj == maj1, go to DONE.
    - Otherwise: cur_maj += 1; t = err + dmin; if t >= 0 then cur_min += step and err = t - dmaj, else err = t.
  - Without a handshake, all state and outputs hold.
- **DONE**: done = 1 for one cycle, then IDLE.
- Pixel count per line = max(|dx|, |dy|) + 1.
- Pixel order runs from lower to higher major coordinate, whatever the input endpoint order.
- start while busy is ignored. No queuing; the command inputs are not sampled.
- Degenerate line (x0 == x1 and y0 == y1) emits exactly one pixel.
- Reset values: IDLE, busy=0, done=0, px_valid=0, px_x=0, px_y=0, px_color=0.
- Reset asserted mid-line drops the line immediately. No done pulse is produced.

## Timing
- start=1 sampled in IDLE at edge N: busy=1 from N+1 (SETUP), PREP at N+2, first px_valid at N+3.
- Throughput: 1 pixel per cycle while px_ready=1.
- px_x, px_y and px_color are registered. They stay stable while px_valid=1 and px_ready=0.
- px_valid never drops without a handshake.
- Last handshake at edge M: done=1 and busy=1 during cycle M+1; busy=0 and IDLE from M+2.
- Earliest next command is accepted at edge M+2.
- Line latency with no stalls = pixels + 4 cycles (start to return to IDLE).
- px_ready is ignored outside DRAW.

## Test plan
- Horizontal line (0,0)->(5,0), px_ready=1 -> 6 pixels x=0..5, y=0 on consecutive cycles, first at start+3; done pulse one cycle after the 6th pixel.
- Steep line (2,1)->(4,7) -> exactly (2,1),(2,2),(3,3),(3,4),(3,5),(4,6),(4,7).
- Reversed line (5,3)->(0,0) -> emits (0,0) first and (5,3) last, 6 pixels; degenerate (7,7)->(7,7) -> one pixel (7,7), then done.
- Backpressure on (0,0)->(3,3) with px_ready low for 3 cycles at pixel 2 -> (1,1) and px_color held stable, no pixels lost or duplicated; start pulses while busy have no effect.
- Full-range diagonal (639,479)->(0,0), color=1 -> 640 pixels, first (0,0), last (639,479), px_color=1 throughout; y monotonic and steps by at most 1 per pixel.
- Reset asserted during pixel 10 of a 100-pixel line -> next cycle px_valid=0, busy=0, done=0; a fresh command afterwards draws correctly from its first pixel.
